// File: rtl/torus_inject_ctrl.sv
// Per-node injection controller: token-bucket rate limiting, packet cap, ejection
// counting and the IDLE/RUN/DRAIN/DONE sequence feeding the network done reduction.
module torus_inject_ctrl #(
    parameter int unsigned X_W       = 2,
    parameter int unsigned Y_W       = 2,
    parameter int unsigned D_W       = 28,
    parameter int unsigned MY_X      = 0,
    parameter int unsigned MY_Y      = 0,
    parameter int unsigned N_PACKETS = 12,
    parameter int unsigned N_EXPECT  = 12,
    parameter int unsigned RATE      = 15,
    parameter int unsigned BURST     = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_gen_v,
    input  logic [D_W-1:0] i_gen_data,
    output logic           o_gen_rdy,
    output logic           o_inj_v,
    output logic [D_W-1:0] o_inj_data,
    input  logic           i_inj_rdy,
    input  logic           i_ej_v,
    output logic [15:0]    o_sent,
    output logic [15:0]    o_recvd,
    output logic           o_self_err,
    output logic           o_timeout,
    output logic           o_done
);

    localparam int unsigned TOK_W = $clog2(BURST + 1);
    localparam int unsigned PER_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int unsigned WDG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TOK_W-1:0] TOK_MAX  = TOK_W'(BURST);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(RATE - 1);
    localparam logic [WDG_W-1:0] WDG_LAST = WDG_W'(TIMEOUT - 1);
    localparam logic [15:0]      SENT_LIM = 16'(N_PACKETS);
    localparam logic [15:0]      RECV_LIM = 16'(N_EXPECT);
    localparam logic [X_W-1:0]   MY_X_V   = X_W'(MY_X);
    localparam logic [Y_W-1:0]   MY_Y_V   = Y_W'(MY_Y);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TOK_W-1:0] r_tokens;
    logic [TOK_W-1:0] w_tokens_nxt;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] w_period_nxt;
    logic [WDG_W-1:0] r_wdog;
    logic [WDG_W-1:0] w_wdog_nxt;
    logic [15:0]      r_sent;
    logic [15:0]      r_recvd;
    logic             r_self_err;
    logic             r_timeout;
    logic             w_timeout_set;

    logic             w_self;
    logic             w_elig;
    logic             w_fire;
    logic             w_drop;
    logic             w_refill;

    assign w_self = (i_gen_data[X_W+Y_W-1:Y_W] == MY_X_V) && (i_gen_data[Y_W-1:0] == MY_Y_V);
    assign w_elig = (r_state == StRun) && (r_tokens != '0) && (r_sent < SENT_LIM);

    // Self-addressed packets are swallowed here and never shown to the router.
    assign o_inj_v    = i_gen_v && w_elig && !w_self;
    assign o_gen_rdy  = w_self ? w_elig : (o_inj_v && i_inj_rdy);
    assign o_inj_data = i_gen_data;

    assign w_fire   = o_inj_v && i_inj_rdy;
    assign w_drop   = i_gen_v && w_elig && w_self;
    assign w_refill = (r_state != StIdle) && (r_period == PER_LAST);

    always_comb begin
        w_period_nxt = r_period;
        if (w_refill) begin
            w_period_nxt = '0;
        end else if (r_state != StIdle) begin
            w_period_nxt = r_period + PER_W'(1);
        end
    end

    // A refill and a fire in the same cycle cancel, so a full bucket stays full.
    always_comb begin
        w_tokens_nxt = r_tokens;
        if (w_refill && !w_fire) begin
            if (r_tokens != TOK_MAX) begin
                w_tokens_nxt = r_tokens + TOK_W'(1);
            end
        end else if (w_fire && !w_refill) begin
            w_tokens_nxt = r_tokens - TOK_W'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_set = 1'b0;
        w_wdog_nxt    = (r_state == StDrain) ? r_wdog + WDG_W'(1) : '0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (r_sent >= SENT_LIM) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_recvd >= RECV_LIM) begin
                    w_state_nxt = StDone;
                end else if (r_wdog == WDG_LAST) begin
                    w_state_nxt   = StDone;
                    w_timeout_set = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StDone;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_tokens   <= TOK_MAX;
            r_period   <= '0;
            r_wdog     <= '0;
            r_sent     <= '0;
            r_recvd    <= '0;
            r_self_err <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tokens <= w_tokens_nxt;
            r_period <= w_period_nxt;
            r_wdog   <= w_wdog_nxt;
            if (w_fire && (r_sent != 16'hFFFF)) begin
                r_sent <= r_sent + 16'd1;
            end
            if (i_ej_v && (r_state != StIdle) && (r_recvd != 16'hFFFF)) begin
                r_recvd <= r_recvd + 16'd1;
            end
            if (w_drop) begin
                r_self_err <= 1'b1;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_sent     = r_sent;
    assign o_recvd    = r_recvd;
    assign o_self_err = r_self_err;
    assign o_timeout  = r_timeout;
    assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_torus_inject_ctrl.sv
// Directed bench for torus_inject_ctrl: burst/refill timing, back-pressure, drain,
// watchdog, self-addressed drops and mid-run reset.
module tb_torus_inject_ctrl;

    localparam int unsigned D_W = 28;
    localparam logic [D_W-1:0] NORM = 28'h0ABC005;
    localparam logic [D_W-1:0] SELF = 28'h0ABC000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_gen_v = 1'b0;
    logic [D_W-1:0] i_gen_data = NORM;
    logic           o_gen_rdy;
    logic           o_inj_v;
    logic [D_W-1:0] o_inj_data;
    logic           i_inj_rdy = 1'b0;
    logic           i_ej_v = 1'b0;
    logic [15:0]    o_sent;
    logic [15:0]    o_recvd;
    logic           o_self_err;
    logic           o_timeout;
    logic           o_done;
    logic           w_fire;

    int n_checks = 0;
    int n_err    = 0;

    torus_inject_ctrl #(
        .TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_gen_v   (i_gen_v),
        .i_gen_data(i_gen_data),
        .o_gen_rdy (o_gen_rdy),
        .o_inj_v   (o_inj_v),
        .o_inj_data(o_inj_data),
        .i_inj_rdy (i_inj_rdy),
        .i_ej_v    (i_ej_v),
        .o_sent    (o_sent),
        .o_recvd   (o_recvd),
        .o_self_err(o_self_err),
        .o_timeout (o_timeout),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    assign w_fire = o_inj_v && i_inj_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_sent"}, o_sent, 0);
        check({pfx, "_recvd"}, o_recvd, 0);
        check({pfx, "_self_err"}, o_self_err, 0);
        check({pfx, "_timeout"}, o_timeout, 0);
        check({pfx, "_done"}, o_done, 0);
        check({pfx, "_gen_rdy"}, o_gen_rdy, 0);
        check({pfx, "_inj_v"}, o_inj_v, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_start = 1'b0;
        i_gen_v = 1'b0;
        i_inj_rdy = 1'b0;
        i_ej_v = 1'b0;
        i_gen_data = NORM;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start at the current negedge; returns in the first RUN cycle (c0).
    task automatic kick();
        i_start = 1'b1;
        i_gen_v = 1'b1;
        i_inj_rdy = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        // Reset values with a valid packet waiting
        rst = 1'b1;
        i_gen_v = 1'b1;
        i_inj_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outs("rst");
        rst = 1'b0;
        i_ej_v = 1'b1;
        @(negedge clk);
        i_ej_v = 1'b0;
        #1;
        check("idle_ej_ignored", o_recvd, 0);
        check("idle_inj_v", o_inj_v, 0);

        // Burst of 4, then one fire per 15 cycles; ejections in RUN and DRAIN
        kick();
        for (int k = 0; k < 130; k++) begin
            i_ej_v = (k >= 10 && k < 16);
            #1;
            check($sformatf("fire_c%0d", k), w_fire,
                  (k < 4) || (k >= 15 && k <= 120 && (k % 15) == 0));
            @(negedge clk);
        end
        #1;
        check("drain_sent", o_sent, 12);
        check("drain_recvd", o_recvd, 6);
        check("drain_inj_v", o_inj_v, 0);
        check("drain_done", o_done, 0);
        check("inj_data_pass", o_inj_data, NORM);
        for (int j = 0; j < 6; j++) begin
            i_ej_v = 1'b1;
            @(negedge clk);
        end
        i_ej_v = 1'b0;
        #1;
        check("ej12_recvd", o_recvd, 12);
        check("ej12_done_early", o_done, 0);
        @(negedge clk);
        #1;
        check("ej12_done", o_done, 1);
        check("ej12_timeout", o_timeout, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("done_holds", o_done, 1);

        // Back-pressure for 50 cycles, then a saturated burst; reset mid-run at sent=7
        do_reset();
        kick();
        for (int k = 0; k < 106; k++) begin
            i_inj_rdy = (k >= 50);
            #1;
            if (k == 0) begin
                check("bp_inj_v", o_inj_v, 1);
                check("bp_gen_rdy", o_gen_rdy, 0);
            end
            if (k >= 50 && k <= 54) begin
                check($sformatf("bp_burst_c%0d", k), w_fire, k < 54);
            end
            if (k == 55) begin
                check("bp_sent4", o_sent, 4);
            end
            if (k == 105) begin
                check("pre_rst_sent", o_sent, 7);
                check("pre_rst_inj_v", o_inj_v, 1);
                rst = 1'b1;
            end
            @(negedge clk);
        end
        #1;
        check_reset_outs("midrst");
        rst = 1'b0;
        kick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("restart_fire_c%0d", k), w_fire, k < 4);
            @(negedge clk);
        end

        // Self-addressed packet is dropped without touching tokens or sent
        do_reset();
        i_gen_data = SELF;
        kick();
        #1;
        check("self_inj_v", o_inj_v, 0);
        check("self_gen_rdy", o_gen_rdy, 1);
        check("self_err_pre", o_self_err, 0);
        @(negedge clk);
        i_gen_data = NORM;
        #1;
        check("self_err_set", o_self_err, 1);
        check("self_sent", o_sent, 0);
        for (int k = 1; k < 6; k++) begin
            check($sformatf("self_fire_c%0d", k), w_fire, k <= 4);
            @(negedge clk);
            #1;
        end
        check("self_sent4", o_sent, 4);
        check("self_err_sticky", o_self_err, 1);

        // Only 5 ejections: watchdog ends the drain 64 cycles after entry
        do_reset();
        kick();
        for (int k = 0; k < 186; k++) begin
            i_ej_v = (k >= 10 && k < 15);
            #1;
            if (k == 121) begin
                check("wd_sent", o_sent, 12);
                check("wd_inj_v", o_inj_v, 0);
            end
            if (k == 185) begin
                check("wd_done_early", o_done, 0);
                check("wd_timeout_early", o_timeout, 0);
            end
            @(negedge clk);
        end
        #1;
        check("wd_done", o_done, 1);
        check("wd_timeout", o_timeout, 1);
        check("wd_recvd", o_recvd, 5);
        @(negedge clk);
        #1;
        check("wd_done_holds", o_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/torus_inject_ctrl.md
# torus_inject_ctrl

Per-node injection controller for the torus NoC. It sits between a node's packet generator and the router's local input port. It rate-limits injection with a token bucket and caps the node at N_PACKETS sent. It counts packets ejected at the node and sequences the node through run, drain and done, which drives the network-level `done` reduction used by the simulation top.

## Interface

Parameters:
- X_W, 2, x coordinate width
- Y_W, 2, y coordinate width
- D_W, 28, packet width; dest x in bits [X_W+Y_W-1:Y_W], dest y in bits [Y_W-1:0]
- MY_X, 0, this node's x coordinate
- MY_Y, 0, this node's y coordinate
- N_PACKETS, 12, packets this node injects
- N_EXPECT, 12, packets this node must eject before done
- RATE, 15, cycles per token refill (≥1)
- BURST, 4, token bucket capacity (≥1)
- TIMEOUT, 1024, drain watchdog limit in cycles

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, single-cycle pulse; leaves IDLE
- gen_v, in, 1, generator has a packet
- gen_data, in, D_W, generator packet
- gen_rdy, out, 1, generator packet accepted this cycle
- inj_v, out, 1, packet to router local port
- inj_data, out, D_W, packet to router (equals gen_data)
- inj_rdy, in, 1, router local port can accept
- ej_v, in, 1, packet ejected at this node this cycle
- sent, out, 16, packets injected
- recvd, out, 16, packets ejected
- self_err, out, 1, sticky; a self-addressed packet was dropped
- timeout, out, 1, sticky; the drain watchdog expired
- done, out, 1, state == DONE

## Operation

- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE to RUN on `start`.
- RUN to DRAIN when `sent` reaches N_PACKETS, evaluated on the registered count.
- DRAIN to DONE when `recvd` ≥ N_EXPECT, or when the watchdog reaches TIMEOUT, which sets `timeout`.
- DONE holds until `rst`.
- If N_PACKETS = 0, RUN goes straight to DRAIN on the next cycle.
- Eligibility: `elig` = (state == RUN) && tokens > 0 && sent < N_PACKETS.
- A self-addressed packet has dest == (MY_X, MY_Y). It never reaches the router:
  - inj_v = 0 for it and gen_rdy = elig.
  - On acceptance it is dropped, `self_err` is set, and it consumes no token and no `sent` count.
- For every other packet: inj_v = gen_v && elig and gen_rdy = inj_v && inj_rdy.
- A fire is inj_v && inj_rdy. It decrements tokens and increments `sent`.
- inj_v must not depend combinationally on inj_rdy.
- The token bucket is tokens[$clog2(BURST+1)-1:0] with a period counter running 0..RATE-1.
  - The counter runs in every state except IDLE.
  - At RATE-1 it wraps to 0 and a refill is generated.
  - Refill adds 1, saturating at BURST.
  - Refill and fire in the same cycle leave tokens unchanged.
  - Refill at BURST together with a fire gives BURST-1+1 = BURST.
- `recvd` increments on ej_v in any state except IDLE. Ejections in IDLE are ignored.
- Both 16-bit counters saturate at 0xFFFF.
- The watchdog counter clears on DRAIN entry and increments each DRAIN cycle.

## Timing

- Reset values:
  - state = IDLE, tokens = BURST, period counter = 0
  - sent = recvd = 0
  - self_err = timeout = done = 0
  - gen_rdy = inj_v = 0
- `rst` mid-operation returns to these values on the next edge, regardless of the handshake in flight.
- Handshake:
  - inj_v is combinational from gen_v and registered state, so there is zero-cycle passthrough.
  - inj_data = gen_data at all times.
  - The generator must hold gen_v and gen_data stable until gen_rdy.
- Injection latency is 0 cycles. `sent` updates the cycle after the fire.
- Peak rate: up to BURST back-to-back fires, then 1 per RATE cycles sustained.
- `done` rises 1 cycle after the DRAIN exit condition is registered. An ej_v that makes recvd = N_EXPECT at edge t gives DONE at edge t+1.
- The watchdog fires when count == TIMEOUT-1. DONE and `timeout` are set at the same edge.

## Test plan

- Reset, start, gen_v held high, inj_rdy held high, RATE=15, BURST=4 -> fires on the 4 cycles after start, the next fire 15 cycles after the first refill window, then 1 per 15 cycles; sent = 12 and state = DRAIN.
- inj_rdy low for 50 cycles during RUN -> tokens saturate at 4 with no overflow; after release, 4 back-to-back fires.
- Pulse ej_v 12 times during RUN and DRAIN -> recvd = 12; done high the cycle after the 12th ejection once in DRAIN; timeout = 0.
- Inject all 12, pulse ej_v only 5 times, TIMEOUT=64 -> done and timeout rise together 64 cycles after DRAIN entry; recvd = 5.
- Present a packet with dest == (MY_X, MY_Y) -> inj_v = 0, gen_rdy = 1, self_err = 1; tokens and sent unchanged.
- Assert rst mid-RUN with sent = 7 -> all outputs return to reset values the next cycle; a new start resumes with tokens = 4.
